// File: rtl/sync_fifo_rd_stream.sv
// Read-side adapter: drains a one-cycle-latency synchronous FIFO into a small
// skid buffer and presents the head entry as a valid/ready stream.
module sync_fifo_rd_stream #(
  parameter int c_DATA_WIDTH = 32,
  parameter int c_BUF_DEPTH  = 4,
  parameter int c_CNT_WIDTH  = 32
) (
  input  logic                               rd_clk,
  input  logic                               rd_rst,
  input  logic                               flush,
  output logic                               fifo_rd_en,
  input  logic                               fifo_rd_empty,
  input  logic [c_DATA_WIDTH-1:0]            fifo_rd_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [c_DATA_WIDTH-1:0]            m_data,
  output logic [$clog2(c_BUF_DEPTH+1)-1:0]   buf_level,
  output logic [c_CNT_WIDTH-1:0]             beat_cnt
);

  localparam int PTR_W = $clog2(c_BUF_DEPTH);
  localparam int LVL_W = $clog2(c_BUF_DEPTH + 1);

  logic [c_DATA_WIDTH-1:0] mem_q [c_BUF_DEPTH];
  logic [PTR_W-1:0]        wptr_q, wptr_d;
  logic [PTR_W-1:0]        rptr_q, rptr_d;
  logic [LVL_W-1:0]        occ_q, occ_d;
  logic                    inflight_q, inflight_d;
  logic [c_CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

  logic [LVL_W:0]          credit_used;
  logic                    capture;
  logic                    pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(c_BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit: buffered words plus the word in flight must leave a free slot.
  always_comb begin
    credit_used = {1'b0, occ_q} + {{LVL_W{1'b0}}, inflight_q};
    fifo_rd_en  = !rd_rst && !flush && !fifo_rd_empty &&
                  (credit_used < (LVL_W+1)'(c_BUF_DEPTH));
    m_valid     = (occ_q != '0);
    m_data      = mem_q[rptr_q];
    buf_level   = occ_q;
    beat_cnt    = beat_cnt_q;
    capture     = inflight_q && !flush;
    pop         = m_valid && m_ready && !flush;
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    inflight_d = fifo_rd_en;
    beat_cnt_d = beat_cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
    end else begin
      if (capture) wptr_d = ptr_inc(wptr_q);
      if (pop) begin
        rptr_d     = ptr_inc(rptr_q);
        beat_cnt_d = beat_cnt_q + c_CNT_WIDTH'(1);
      end
      if (capture && !pop)      occ_d = occ_q + LVL_W'(1);
      else if (pop && !capture) occ_d = occ_q - LVL_W'(1);
    end
  end

  // Control state boundary: pointers, occupancy, in-flight flag, beat counter.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Data boundary: FIFO read data lands in the skid buffer one cycle after the read.
  always_ff @(posedge rd_clk) begin
    if (capture && !rd_rst) mem_q[wptr_q] <= fifo_rd_data;
  end

  a_no_capture_when_full : assert property (
    @(posedge rd_clk) disable iff (rd_rst)
      (inflight_q && !flush) |-> (occ_q != LVL_W'(c_BUF_DEPTH))
  );

endmodule
